config_serializer: RTL and testbench

CONFIG_SERIALIZER -- requirements
Module: config_serializer

---
 rtl/config_pkg.sv | 30 +++
 rtl/config_fifo.sv | 51 +++++
 rtl/config_serializer.sv | 161 ++++++++++++++++
 tb/tb_config_serializer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Shared types and constants for the configuration serializer.
package config_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        SET
    } cfg_state_e;

    // FIFO entries are sized for the widest supported build; narrower builds leave the upper bits zero.
    localparam int unsigned MAX_WORD_W = 64;
    localparam int unsigned MAX_COL_W  = 8;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef struct packed {
        logic [MAX_WORD_W-1:0] data;
        logic [MAX_COL_W-1:0]  col;
        logic                  last;
    } fifo_entry_t;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc_in, input logic bit_in);
        logic fb;
        fb = crc_in[15] ^ bit_in;
        return {crc_in[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/config_fifo.sv
// Synchronous FIFO with full/empty flags; DEPTH must be a power of two (>= 2).
module config_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/config_serializer.sv
// Buffers configuration words and shifts them LSB-first into per-column fabric chains.
// Optional CRC-16-CCITT over shifted bits: define CONFIG_SERIALIZER_CRC_EN.
module config_serializer
    import config_pkg::*;
#(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned NUM_COLS   = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned COL_W     = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_data,
    input  logic [COL_W-1:0]    in_col,
    input  logic                in_last,
    output logic [NUM_COLS-1:0] cen,
    output logic [NUM_COLS-1:0] shift_out,
    output logic [NUM_COLS-1:0] set_out,
    output logic                cfg_bit,
    output logic                busy,
    output logic                err
`ifdef CONFIG_SERIALIZER_CRC_EN
    ,
    output logic [15:0]         crc
`endif
);

    localparam int unsigned CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    fifo_entry_t         push_entry, pop_entry;
    logic                fifo_full, fifo_empty, push, pop, col_ok, handshake;
    logic                unused_pop_bits;

    cfg_state_e          state_q, state_d;
    logic [WORD_W-1:0]   sreg_q, sreg_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic                last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_COLS-1:0] cen_q, cen_d;
    logic                err_q, err_d;
    logic [NUM_COLS-1:0] col_onehot;

    assign in_ready  = !fifo_full;
    assign handshake = in_valid && !fifo_full;
    assign col_ok    = 32'(in_col) < 32'(NUM_COLS);
    assign push      = handshake && col_ok;
    assign err_d     = err_q | (handshake && !col_ok);

    always_comb begin
        push_entry                   = '0;
        push_entry.data[WORD_W-1:0]  = in_data;
        push_entry.col[COL_W-1:0]    = in_col;
        push_entry.last              = in_last;
    end

    config_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (pop_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign unused_pop_bits = ^pop_entry;
    assign col_onehot      = NUM_COLS'(1) << col_q;

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        col_d     = col_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        cen_d     = cen_q;
        pop       = 1'b0;
        shift_out = '0;
        set_out   = '0;
        cfg_bit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = LOAD;
            end
            LOAD: begin
                pop     = 1'b1;
                sreg_d  = pop_entry.data[WORD_W-1:0];
                col_d   = pop_entry.col[COL_W-1:0];
                last_d  = pop_entry.last;
                cnt_d   = '0;
                // Switching columns drops the previous enable; same column keeps it high across LOAD.
                cen_d   = NUM_COLS'(1) << pop_entry.col[COL_W-1:0];
                state_d = SHIFT;
            end
            SHIFT: begin
                cfg_bit   = sreg_q[0];
                shift_out = col_onehot;
                sreg_d    = sreg_q >> 1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WORD_W - 1)) begin
                    if (last_q)           state_d = SET;
                    else if (!fifo_empty) state_d = LOAD;
                    else                  state_d = IDLE;
                end
            end
            SET: begin
                set_out = col_onehot;
                cen_d   = '0;
                state_d = fifo_empty ? IDLE : LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            col_q   <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            cen_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            col_q   <= col_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            cen_q   <= cen_d;
            err_q   <= err_d;
        end
    end

    assign cen  = cen_q;
    assign err  = err_q;
    assign busy = !fifo_empty || (state_q != IDLE);

`ifdef CONFIG_SERIALIZER_CRC_EN
    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (state_q == SHIFT)    crc_d = crc16_step(crc_q, sreg_q[0]);
        else if (state_q == SET) crc_d = CRC_INIT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_q <= CRC_INIT;
        else     crc_q <= crc_d;
    end

    assign crc = crc_q;
`endif

endmodule

// File: tb/tb_config_serializer.sv
// Randomized scoreboard bench for config_serializer; NUM_COLS=3 so an out-of-range column is drivable.
module tb_config_serializer;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned NUM_COLS   = 3;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned COL_W      = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid, in_ready, in_last;
    logic [WORD_W-1:0]   in_data;
    logic [COL_W-1:0]    in_col;
    logic [NUM_COLS-1:0] cen, shift_out, set_out;
    logic                cfg_bit, busy, err;
`ifdef CONFIG_SERIALIZER_CRC_EN
    logic [15:0]         crc;
`endif

    always #5 clk = ~clk;

    config_serializer #(
        .WORD_W     (WORD_W),
        .NUM_COLS   (NUM_COLS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_col    (in_col),
        .in_last   (in_last),
        .cen       (cen),
        .shift_out (shift_out),
        .set_out   (set_out),
        .cfg_bit   (cfg_bit),
        .busy      (busy),
        .err       (err)
`ifdef CONFIG_SERIALIZER_CRC_EN
        ,
        .crc       (crc)
`endif
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: words that should eventually appear on the serial output, in order.
    typedef struct {
        logic [WORD_W-1:0] data;
        int unsigned       col;
        bit                last;
    } word_t;

    word_t       exp_q[$];
    bit          exp_err;
    bit          mon_en = 1'b0;

    logic [WORD_W-1:0]   cur_word;
    int unsigned         nbits, cur_col, words_done;
    logic [NUM_COLS-1:0] set_expect;
    int unsigned         cen_cnt[NUM_COLS], set_cnt[NUM_COLS], shift_cnt[NUM_COLS];
    bit                  saw_stall;
`ifdef CONFIG_SERIALIZER_CRC_EN
    logic [15:0]         crc_m, crc_at_set;
`endif

    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic b);
        logic [16:0] t;
        t = {c, 1'b0};
        if (c[15] ^ b) t[15:0] = t[15:0] ^ 16'h1021;
        return t[15:0];
    endfunction

    task automatic clear_counts();
        for (int i = 0; i < NUM_COLS; i++) begin
            cen_cnt[i] = 0;
            set_cnt[i] = 0;
            shift_cnt[i] = 0;
        end
        saw_stall = 1'b0;
    endtask

    function automatic int unsigned sum_of(input int unsigned a[NUM_COLS]);
        int unsigned s = 0;
        for (int i = 0; i < NUM_COLS; i++) s += a[i];
        return s;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            nbits = 0;
            set_expect = '0;
`ifdef CONFIG_SERIALIZER_CRC_EN
            crc_m = 16'hFFFF;
`endif
        end else if (mon_en) begin
            word_t               w;
            logic [NUM_COLS-1:0] oh;
            check_eq("shift_onehot", $countones(shift_out) > 1, 0);
            check_eq("cen_onehot", $countones(cen) > 1, 0);
            check_eq("set_out", set_out, set_expect);
            if (set_out != '0) check_eq("cen_in_set", cen, set_out);
`ifdef CONFIG_SERIALIZER_CRC_EN
            check_eq("crc_track", crc, crc_m);
            if (set_out != '0) crc_at_set = crc;
`endif
            set_expect = '0;
            if (!in_ready) saw_stall = 1'b1;
            for (int i = 0; i < NUM_COLS; i++) begin
                if (cen[i])       cen_cnt[i]++;
                if (set_out[i])   set_cnt[i]++;
                if (shift_out[i]) shift_cnt[i]++;
            end
            if (shift_out == '0) begin
                check_eq("cfg_bit_idle", cfg_bit, 0);
`ifdef CONFIG_SERIALIZER_CRC_EN
                if (set_out != '0) crc_m = 16'hFFFF;
`endif
            end else begin
                check_eq("cen_in_shift", cen, shift_out);
                if (nbits == 0) begin
                    for (int i = 0; i < NUM_COLS; i++) if (shift_out[i]) cur_col = i;
                end else begin
                    oh = '0;
                    oh[cur_col] = 1'b1;
                    check_eq("shift_col_stable", shift_out, oh);
                end
                cur_word[nbits] = cfg_bit;
`ifdef CONFIG_SERIALIZER_CRC_EN
                crc_m = crc_ref(crc_m, cfg_bit);
`endif
                nbits++;
                if (nbits == WORD_W) begin
                    nbits = 0;
                    words_done++;
                    check_eq("word_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        w = exp_q.pop_front();
                        check_eq("word_data", cur_word, w.data);
                        check_eq("word_col", cur_col, w.col);
                        if (w.last) begin
                            set_expect = '0;
                            set_expect[w.col] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_col = '0;
        in_last = 1'b0;
        exp_q.delete();
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        nbits = 0;
        set_expect = '0;
        clear_counts();
        @(negedge clk);
    endtask

    // Called at a negedge; returns at a negedge with in_valid low.
    task automatic send(input logic [WORD_W-1:0] d, input int unsigned c, input bit l);
        word_t w;
        bit    rdy = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_col   = COL_W'(c);
        in_last  = l;
        for (int t = 0; t < 500; t++) begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) break;
            @(negedge clk);
        end
        check_eq("send_accepted", rdy, 1);
        if (rdy) begin
            if (c < NUM_COLS) begin
                w.data = d;
                w.col  = c;
                w.last = l;
                exp_q.push_back(w);
            end else begin
                exp_err = 1'b1;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned t = 0;
        while ((busy || exp_q.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_eq("drain_busy", busy, 0);
        check_eq("drain_queue", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned wd, good, t;
        logic [WORD_W-1:0] d;
        words_done = 0;
        clear_counts();
        do_reset();
        mon_en = 1'b1;

        check_eq("rst_cen", cen, 0);
        check_eq("rst_shift_out", shift_out, 0);
        check_eq("rst_set_out", set_out, 0);
        check_eq("rst_cfg_bit", cfg_bit, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_in_ready", in_ready, 1);
`ifdef CONFIG_SERIALIZER_CRC_EN
        check_eq("rst_crc", crc, 16'hFFFF);
`endif

        // Single committed word
        wd = words_done;
        send(32'h0000_0005, 1, 1'b1);
        wait_idle();
        check_eq("single_words", words_done - wd, 1);
        check_eq("single_shift_cnt", shift_cnt[1], 32);
        check_eq("single_cen_cnt", cen_cnt[1], 33);
        check_eq("single_set_cnt", set_cnt[1], 1);
        check_eq("single_cen_after", cen, 0);

        // Back-to-back words overfill the FIFO
        clear_counts();
        wd = words_done;
        for (int i = 0; i < 5; i++) send($urandom, $urandom_range(0, NUM_COLS - 1), i == 4);
        wait_idle();
        check_eq("bp_stall_seen", saw_stall, 1);
        check_eq("bp_words", words_done - wd, 5);

        // Column switch without commit
        clear_counts();
        send($urandom, 0, 1'b0);
        send($urandom, 2, 1'b1);
        wait_idle();
        check_eq("sw_set0", set_cnt[0], 0);
        check_eq("sw_set2", set_cnt[2], 1);
        check_eq("sw_shift0", shift_cnt[0], 32);
        check_eq("sw_cen_after", cen, 0);

        // Out-of-range column
        clear_counts();
        wd = words_done;
        check_eq("bad_err_before", err, 0);
        send($urandom, NUM_COLS, 1'b1);
        repeat (40) @(negedge clk);
        check_eq("bad_err", err, 1);
        check_eq("bad_words", words_done - wd, 0);
        check_eq("bad_shifts", sum_of(shift_cnt), 0);
        check_eq("bad_sets", sum_of(set_cnt), 0);
        check_eq("bad_busy", busy, 0);
        do_reset();
        check_eq("bad_err_cleared", err, 0);

        // Randomized traffic
        wd = words_done;
        good = 0;
        for (int i = 0; i < 24; i++) begin
            t = $urandom_range(0, NUM_COLS);
            if (t < NUM_COLS) good++;
            send($urandom, t, $urandom_range(0, 1) == 1 || i == 23);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        check_eq("rand_words", words_done - wd, good);
        check_eq("rand_err", err, exp_err);

        // Reset during shift cycle 10 with a second word still queued
        do_reset();
        send($urandom, 1, 1'b1);
        send($urandom, 2, 1'b1);
        t = 0;
        while (shift_cnt[1] < 10 && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        check_eq("mid_reached", shift_cnt[1], 10);
        rst = 1'b1;
        exp_q.delete();
        exp_err = 1'b0;
        @(negedge clk);
        check_eq("mid_cen", cen, 0);
        check_eq("mid_shift_out", shift_out, 0);
        check_eq("mid_set_out", set_out, 0);
        check_eq("mid_cfg_bit", cfg_bit, 0);
        check_eq("mid_busy", busy, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        clear_counts();
        repeat (50) @(negedge clk);
        check_eq("mid_no_set", sum_of(set_cnt), 0);
        check_eq("mid_no_shift", sum_of(shift_cnt), 0);
        check_eq("mid_busy_after", busy, 0);
        check_eq("mid_ready_after", in_ready, 1);
        check_eq("mid_err_after", err, 0);

`ifdef CONFIG_SERIALIZER_CRC_EN
        do_reset();
        d = '0;
        crc_at_set = 16'h0000;
        send(d, 0, 1'b1);
        wait_idle();
        begin
            logic [15:0] c = 16'hFFFF;
            for (int i = 0; i < WORD_W; i++) c = crc_ref(c, d[i]);
            check_eq("crc_at_set", crc_at_set, c);
        end
        check_eq("crc_after_set", crc, 16'hFFFF);
`else
        d = '0;
        check_eq("final_cfg_bit", cfg_bit, d[0]);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
